// File: rtl/writeback_stage_pl_if.sv
// writeback_stage_pl_if
//   Bundles the MEM->WB handshake, the MEM-stage payload and the WB-stage
//   register-file outputs into one interface.
//   master : the side that drives the MEM payload, flush and rf_ready
//            (memory stage / testbench).
//   slave  : the writeback stage itself.
//   Signals
//     valid_m, ready_m, flush, rf_ready      handshake and control
//     ResultSrcM, funct3M, RegWriteM, RdM    MEM-stage control fields
//     ALU_ResultM, ReadDataM, PCPlus4M,
//     ExtDataM                               MEM-stage data sources
//     valid_w, RegWriteW, RdW, ResultW,
//     misalign_w, instret                    WB-stage outputs
interface writeback_stage_pl_if #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 64
) ();

  logic                  valid_m;
  logic                  ready_m;
  logic                  flush;
  logic                  rf_ready;
  logic [1:0]            ResultSrcM;
  logic [2:0]            funct3M;
  logic                  RegWriteM;
  logic [REG_ADDR_W-1:0] RdM;
  logic [XLEN-1:0]       ALU_ResultM;
  logic [XLEN-1:0]       ReadDataM;
  logic [XLEN-1:0]       PCPlus4M;
  logic [XLEN-1:0]       ExtDataM;
  logic                  valid_w;
  logic                  RegWriteW;
  logic [REG_ADDR_W-1:0] RdW;
  logic [XLEN-1:0]       ResultW;
  logic                  misalign_w;
  logic [CNT_W-1:0]      instret;

  modport master (
    output valid_m, flush, rf_ready, ResultSrcM, funct3M, RegWriteM, RdM,
           ALU_ResultM, ReadDataM, PCPlus4M, ExtDataM,
    input  ready_m, valid_w, RegWriteW, RdW, ResultW, misalign_w, instret
  );

  modport slave (
    input  valid_m, flush, rf_ready, ResultSrcM, funct3M, RegWriteM, RdM,
           ALU_ResultM, ReadDataM, PCPlus4M, ExtDataM,
    output ready_m, valid_w, RegWriteW, RdW, ResultW, misalign_w, instret
  );

endinterface

// File: rtl/writeback_stage_pl.sv
// writeback_stage_pl
//   Registered writeback stage of the 5-stage RISC-V pipeline. Holds the
//   MEM/WB register behind a valid/ready handshake, formats load data
//   (byte/half/word/double lane select with sign or zero extension), picks
//   the writeback value from ALU / load / PC+4 / ExtData, drives the
//   register-file write port and counts retired instructions.
//   Ports
//     clk   rising-edge clock
//     rst   asynchronous, active-low reset
//     bus   writeback_stage_pl_if.slave (handshake, MEM payload, WB outputs)
module writeback_stage_pl #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  writeback_stage_pl_if.slave   bus
);

  localparam int OFF_W = $clog2(XLEN / 8);

  logic                  valid_q;
  logic                  reg_we_q;
  logic                  misalign_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic [XLEN-1:0]       result_q;
  logic [CNT_W-1:0]      instret_q;

  logic                  ready;
  logic                  retire;
  logic                  take;
  logic [OFF_W-1:0]      off;
  logic [XLEN-1:0]       shifted;
  logic [XLEN-1:0]       load_val;
  logic                  load_mis;
  logic [XLEN-1:0]       result_d;
  logic                  misalign_d;

  // A slot is free when nothing is held or the held entry leaves this cycle.
  // flush kills the incoming instruction, so it never counts as a transfer.
  always_comb begin
    ready  = !valid_q || bus.rf_ready;
    retire = valid_q && bus.rf_ready;
    take   = bus.valid_m && ready && !bus.flush;
  end

  // Shift the addressed lane down to bit 0 so every load size can simply
  // take the low bits and extend them.
  always_comb begin
    off     = bus.ALU_ResultM[OFF_W-1:0];
    shifted = bus.ReadDataM >> {off, 3'b000};
  end

  // Load formatting and alignment/legality check. Illegal encodings are
  // flagged the same way as misaligned accesses.
  always_comb begin
    load_val = '0;
    load_mis = 1'b0;
    case (bus.funct3M)
      3'b000: load_val = XLEN'($signed(shifted[7:0]));
      3'b100: load_val = XLEN'(shifted[7:0]);
      3'b001: begin
        if (off[0]) load_mis = 1'b1;
        else        load_val = XLEN'($signed(shifted[15:0]));
      end
      3'b101: begin
        if (off[0]) load_mis = 1'b1;
        else        load_val = XLEN'(shifted[15:0]);
      end
      3'b010: begin
        if (off[1:0] != 2'b00) load_mis = 1'b1;
        else                   load_val = XLEN'($signed(shifted[31:0]));
      end
      3'b011: begin
        if (XLEN == 64 && off == '0) load_val = shifted;
        else                         load_mis = 1'b1;
      end
      3'b110: begin
        if (XLEN == 64 && off[1:0] == 2'b00) load_val = XLEN'(shifted[31:0]);
        else                                 load_mis = 1'b1;
      end
      default: load_mis = 1'b1;
    endcase
  end

  // Source select. A misaligned load passes the raw memory word through so
  // the trap handler can inspect it.
  always_comb begin
    result_d   = bus.ALU_ResultM;
    misalign_d = 1'b0;
    case (bus.ResultSrcM)
      2'b01: begin
        result_d   = load_mis ? bus.ReadDataM : load_val;
        misalign_d = load_mis;
      end
      2'b10:   result_d = bus.PCPlus4M;
      2'b11:   result_d = bus.ExtDataM;
      default: result_d = bus.ALU_ResultM;
    endcase
  end

  // MEM/WB register and retire counter. A retire still counts when a flush
  // lands in the same cycle; flush only empties the slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q    <= 1'b0;
      reg_we_q   <= 1'b0;
      misalign_q <= 1'b0;
      rd_q       <= '0;
      result_q   <= '0;
      instret_q  <= '0;
    end else begin
      if (retire) instret_q <= instret_q + CNT_W'(1);
      if (bus.flush) begin
        valid_q <= 1'b0;
      end else if (take) begin
        valid_q    <= 1'b1;
        reg_we_q   <= bus.RegWriteM;
        rd_q       <= bus.RdM;
        result_q   <= result_d;
        misalign_q <= misalign_d;
      end else if (retire) begin
        valid_q <= 1'b0;
      end
    end
  end

  // x0 writes and faulting loads still retire but never reach the file.
  assign bus.ready_m    = ready;
  assign bus.valid_w    = valid_q;
  assign bus.RegWriteW  = valid_q && reg_we_q && (rd_q != '0) && !misalign_q;
  assign bus.RdW        = rd_q;
  assign bus.ResultW    = result_q;
  assign bus.misalign_w = misalign_q;
  assign bus.instret    = instret_q;

endmodule

// File: tb/tb_writeback_stage_pl.sv
// tb_writeback_stage_pl
//   Self-checking bench for writeback_stage_pl (XLEN=32). Directed sequences
//   for the load formats, x0 suppression, back-pressure, flush, counter wrap
//   and asynchronous reset, followed by randomized traffic. Expected values
//   come from a transaction-level model of the stage kept in this module.
module tb_writeback_stage_pl;

  localparam int XLEN = 32;
  localparam int RW   = 5;
  localparam int CW   = 64;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  writeback_stage_pl_if #(.XLEN(XLEN), .REG_ADDR_W(RW), .CNT_W(CW)) bus ();

  writeback_stage_pl #(.XLEN(XLEN), .REG_ADDR_W(RW), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    bit        valid;
    bit        flush;
    bit        rf_ready;
    bit [1:0]  src;
    bit [2:0]  f3;
    bit        we;
    bit [4:0]  rd;
    bit [31:0] alu;
    bit [31:0] rdata;
    bit [31:0] pc4;
    bit [31:0] ext;
  } stim_t;

  int checks   = 0;
  int failures = 0;

  // Model of what the WB slot holds and how many instructions have left it.
  bit        m_valid  = 1'b0;
  bit        m_we     = 1'b0;
  bit        m_mis    = 1'b0;
  bit [4:0]  m_rd     = '0;
  bit [31:0] m_result = '0;
  bit [63:0] m_cnt    = '0;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Load result computed from the ISA rules with plain arithmetic:
  // (x ^ signbit) - signbit sign-extends a field of known width.
  function automatic void refLoad(input bit [2:0] f3, input bit [31:0] addr,
                                  input bit [31:0] data, output bit mis,
                                  output bit [31:0] val);
    int        off;
    bit [31:0] lane;
    off  = int'(addr % 4);
    lane = data >> (8 * off);
    mis  = 1'b0;
    val  = '0;
    case (f3)
      3'd0: val = ((lane & 32'hFF) ^ 32'h80) - 32'h80;
      3'd4: val = lane & 32'hFF;
      3'd1: if (off % 2 != 0) mis = 1'b1; else val = ((lane & 32'hFFFF) ^ 32'h8000) - 32'h8000;
      3'd5: if (off % 2 != 0) mis = 1'b1; else val = lane & 32'hFFFF;
      3'd2: if (off != 0) mis = 1'b1; else val = data;
      default: mis = 1'b1;
    endcase
    if (mis) val = data;
  endfunction

  function automatic stim_t mk(input bit valid, input bit flush, input bit rfr,
                               input bit [1:0] src, input bit [2:0] f3, input bit we,
                               input bit [4:0] rd, input bit [31:0] alu,
                               input bit [31:0] rdata, input bit [31:0] pc4,
                               input bit [31:0] ext);
    stim_t s;
    s.valid = valid; s.flush = flush; s.rf_ready = rfr; s.src = src; s.f3 = f3;
    s.we = we; s.rd = rd; s.alu = alu; s.rdata = rdata; s.pc4 = pc4; s.ext = ext;
    return s;
  endfunction

  task automatic checkState();
    checkOutput("valid_w", bus.valid_w, m_valid);
    checkOutput("RegWriteW", bus.RegWriteW, m_valid && m_we && (m_rd != 0) && !m_mis);
    checkOutput("instret", bus.instret, m_cnt);
    if (m_valid) begin
      checkOutput("RdW", bus.RdW, m_rd);
      checkOutput("ResultW", bus.ResultW, m_result);
      checkOutput("misalign_w", bus.misalign_w, m_mis);
    end
  endtask

  // Drive one cycle of inputs, check the handshake, advance the model and
  // check the registered outputs just after the edge.
  task automatic applyStimulus(input stim_t s);
    bit retire;
    bit take;
    bit mis;
    bit [31:0] val;
    bus.valid_m     = s.valid;
    bus.flush       = s.flush;
    bus.rf_ready    = s.rf_ready;
    bus.ResultSrcM  = s.src;
    bus.funct3M     = s.f3;
    bus.RegWriteM   = s.we;
    bus.RdM         = s.rd;
    bus.ALU_ResultM = s.alu;
    bus.ReadDataM   = s.rdata;
    bus.PCPlus4M    = s.pc4;
    bus.ExtDataM    = s.ext;
    #2;
    checkOutput("ready_m", bus.ready_m, !m_valid || s.rf_ready);
    retire = m_valid && s.rf_ready;
    take   = s.valid && (!m_valid || s.rf_ready) && !s.flush;
    if (retire) m_cnt = m_cnt + 1;
    if (s.flush) begin
      m_valid = 1'b0;
    end else if (take) begin
      m_valid = 1'b1;
      m_we    = s.we;
      m_rd    = s.rd;
      m_mis   = 1'b0;
      case (s.src)
        2'd0: m_result = s.alu;
        2'd1: begin
          refLoad(s.f3, s.alu, s.rdata, mis, val);
          m_result = val;
          m_mis    = mis;
        end
        2'd2: m_result = s.pc4;
        default: m_result = s.ext;
      endcase
    end else if (retire) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    checkState();
  endtask

  task automatic modelReset();
    m_valid = 1'b0; m_we = 1'b0; m_mis = 1'b0;
    m_rd = '0; m_result = '0; m_cnt = '0;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_valid_w"}, bus.valid_w, 0);
    checkOutput({tag, "_RegWriteW"}, bus.RegWriteW, 0);
    checkOutput({tag, "_RdW"}, bus.RdW, 0);
    checkOutput({tag, "_ResultW"}, bus.ResultW, 0);
    checkOutput({tag, "_misalign_w"}, bus.misalign_w, 0);
    checkOutput({tag, "_instret"}, bus.instret, 0);
    checkOutput({tag, "_ready_m"}, bus.ready_m, 1);
  endtask

  initial begin
    stim_t s;
    bit [31:0] held;

    bus.valid_m = 1'b0; bus.flush = 1'b0; bus.rf_ready = 1'b0;
    bus.ResultSrcM = '0; bus.funct3M = '0; bus.RegWriteM = 1'b0; bus.RdM = '0;
    bus.ALU_ResultM = '0; bus.ReadDataM = '0; bus.PCPlus4M = '0; bus.ExtDataM = '0;

    // Power-on reset
    #12;
    checkAllZero("reset");
    modelReset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Load formatting
    applyStimulus(mk(1, 0, 1, 2'd1, 3'd0, 1, 5'd5, 32'h1000_0000, 32'h8000_00F0, 0, 0));
    checkOutput("lb_const", bus.ResultW, 32'hFFFF_FFF0);
    checkOutput("lb_we_const", bus.RegWriteW, 1);
    applyStimulus(mk(1, 0, 1, 2'd1, 3'd5, 1, 5'd6, 32'h1000_0002, 32'h8001_1234, 0, 0));
    checkOutput("lhu_const", bus.ResultW, 32'h0000_8001);
    applyStimulus(mk(1, 0, 1, 2'd1, 3'd1, 1, 5'd7, 32'h1000_0001, 32'h8001_1234, 0, 0));
    checkOutput("lh_mis_const", bus.misalign_w, 1);
    checkOutput("lh_mis_we_const", bus.RegWriteW, 0);

    // PC+4 source, then x0 destination
    applyStimulus(mk(1, 0, 1, 2'd2, 3'd0, 1, 5'd1, 32'h0, 32'h0, 32'h104, 0));
    checkOutput("pc4_const", bus.ResultW, 32'h104);
    applyStimulus(mk(1, 0, 1, 2'd2, 3'd0, 1, 5'd0, 32'h0, 32'h0, 32'h104, 0));
    checkOutput("x0_we_const", bus.RegWriteW, 0);

    // Back-pressure for three cycles, then two back-to-back retires
    held = bus.ResultW;
    for (int i = 0; i < 3; i++)
      applyStimulus(mk(1, 0, 0, 2'd0, 3'd0, 1, 5'd3, 32'h0000_AAAA, 0, 0, 0));
    checkOutput("hold_stable", bus.ResultW, held);
    applyStimulus(mk(1, 0, 1, 2'd0, 3'd0, 1, 5'd3, 32'h0000_AAAA, 0, 0, 0));
    applyStimulus(mk(1, 0, 1, 2'd3, 3'd0, 1, 5'd4, 0, 0, 0, 32'hCAFE_0001));

    // Flush with an incoming instruction and a retiring held one
    applyStimulus(mk(1, 1, 1, 2'd0, 3'd0, 1, 5'd9, 32'h1234_5678, 0, 0, 0));
    applyStimulus(mk(0, 0, 1, 2'd0, 3'd0, 0, 5'd0, 0, 0, 0, 0));

    // Counter wrap at 2^64-1
    applyStimulus(mk(1, 0, 0, 2'd0, 3'd0, 1, 5'd2, 32'h55, 0, 0, 0));
    force dut.instret_q = '1;
    #1;
    release dut.instret_q;
    m_cnt = '1;
    applyStimulus(mk(0, 0, 1, 2'd0, 3'd0, 0, 5'd0, 0, 0, 0, 0));
    checkOutput("instret_wrap", bus.instret, 0);

    // Asynchronous reset while an instruction is held
    applyStimulus(mk(1, 0, 0, 2'd0, 3'd0, 1, 5'd8, 32'h77, 0, 0, 0));
    applyStimulus(mk(1, 0, 0, 2'd0, 3'd0, 1, 5'd8, 32'h88, 0, 0, 0));
    bus.valid_m = 1'b0;
    rst = 1'b0;
    #1;
    checkAllZero("midreset");
    modelReset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      s = mk($urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0,
             $urandom_range(0, 9) < 7, 2'($urandom_range(0, 3)),
             3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
             5'($urandom_range(0, 31)), $urandom, $urandom, $urandom, $urandom);
      applyStimulus(s);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
